// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//
// Memory-access pipeline stage between EX and WB. Takes one instruction per
// handshake, waits for the data-SRAM response strobe, performs sub-word load
// extraction with sign/zero extension, and buffers the response while WB
// stalls. A flush cancels the held instruction; if its response is still
// outstanding the stage drains (swallows) that response before reopening.
//
// Optional feature macro: MS_LWLR_EN
//   defined   : op 101 (LWL) / 110 (LWR) merge the loaded bytes with es_rt_value
//   undefined : op 101 / 110 behave as LW and es_rt_value is not used
//
// Parameters
//   DATA_W : data-SRAM read width, 32 or 64 (64: word lane chosen by addr[2])
//   PC_W   : PC width
//   DEST_W : destination register index width
//
// Ports
//   clk, resetn              : clock (rising edge), async active-low reset
//   es_to_ms_valid/ms_allowin: EX -> MS handshake
//   es_* payload             : load flag, request-issued flag, write enable,
//                              destination, ALU result/address, load type,
//                              old rt value, PC
//   data_sram_data_ok/rdata  : one-cycle response strobe and data
//   ms_flush                 : cancel the instruction held in MS
//   ws_allowin/ms_to_ws_valid: MS -> WB handshake
//   ms_gr_we, ms_dest, ms_final_result, ms_pc : payload to WB
//   ms_fwd_valid/dest/result/busy             : forwarding to decode
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEST_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic              es_res_from_mem,
    input  logic              es_req_issued,
    input  logic              es_gr_we,
    input  logic [DEST_W-1:0] es_dest,
    input  logic [31:0]       es_alu_result,
    input  logic [2:0]        es_load_op,
    input  logic [31:0]       es_rt_value,
    input  logic [PC_W-1:0]   es_pc,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              ms_flush,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic              ms_gr_we,
    output logic [DEST_W-1:0] ms_dest,
    output logic [31:0]       ms_final_result,
    output logic [PC_W-1:0]   ms_pc,
    output logic              ms_fwd_valid,
    output logic [DEST_W-1:0] ms_fwd_dest,
    output logic [31:0]       ms_fwd_result,
    output logic              ms_fwd_busy
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;

    // Sub-word extraction from the selected 32-bit word lane. LWL places the
    // low b+1 bytes of the word in the result's high bytes; LWR places the
    // high b+1 bytes of the word in the result's low bytes; rt fills the rest.
    function automatic logic [31:0] extract_load(
        input logic [2:0]  op,
        input logic [1:0]  b,
        input logic [31:0] w,
        input logic [31:0] rt
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (b)
            2'd0:    byte_v = w[7:0];
            2'd1:    byte_v = w[15:8];
            2'd2:    byte_v = w[23:16];
            default: byte_v = w[31:24];
        endcase
        // addr[0] deliberately ignored for halfwords
        half_v = b[1] ? w[31:16] : w[15:0];
        case (op)
            OP_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  res_v = {24'd0, byte_v};
            OP_LH:   res_v = {{16{half_v[15]}}, half_v};
            OP_LHU:  res_v = {16'd0, half_v};
`ifdef MS_LWLR_EN
            OP_LWL: begin
                case (b)
                    2'd0:    res_v = {w[7:0],  rt[23:0]};
                    2'd1:    res_v = {w[15:0], rt[15:0]};
                    2'd2:    res_v = {w[23:0], rt[7:0]};
                    default: res_v = w;
                endcase
            end
            OP_LWR: begin
                case (b)
                    2'd0:    res_v = {rt[31:8],  w[31:24]};
                    2'd1:    res_v = {rt[31:16], w[31:16]};
                    2'd2:    res_v = {rt[31:24], w[31:8]};
                    default: res_v = w;
                endcase
            end
`endif
            default: res_v = w;
        endcase
        return res_v;
    endfunction

    logic [1:0]        state_q, state_d;
    logic              gr_we_q, gr_we_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [31:0]       alu_q, alu_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       rt_q, rt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              load_q, load_d;       // load with a request in flight
    logic              res_mem_q, res_mem_d; // any load (no request -> result 0)
    logic [31:0]       buf_q, buf_d;         // response captured while WB stalls

    logic        ready_go_s;
    logic        accept_s;
    logic [1:0]  accept_state_s;
    logic [31:0] live_word_s;
    logic [31:0] word_s;
    logic        valid_state_s;

    generate
        if (DATA_W == 64) begin : g_lane64
            assign live_word_s = alu_q[2] ? data_sram_rdata[DATA_W-1:32] : data_sram_rdata[31:0];
        end else begin : g_lane32
            assign live_word_s = data_sram_rdata[31:0];
        end
    endgenerate

    assign ready_go_s     = (state_q == S_DONE) || ((state_q == S_WAIT) && data_sram_data_ok);
    assign ms_allowin     = (state_q == S_EMPTY) || (ready_go_s && ws_allowin);
    assign accept_s       = es_to_ms_valid && ms_allowin;
    assign accept_state_s = (es_res_from_mem && es_req_issued) ? S_WAIT : S_DONE;
    assign ms_to_ws_valid = ready_go_s && !ms_flush;
    assign valid_state_s  = (state_q == S_WAIT) || (state_q == S_DONE);

    // WAIT uses the live response; DONE uses the captured one
    assign word_s          = (state_q == S_WAIT) ? live_word_s : buf_q;
    assign ms_final_result = load_q    ? extract_load(op_q, alu_q[1:0], word_s, rt_q) :
                             res_mem_q ? 32'd0 : alu_q;

    assign ms_gr_we      = gr_we_q;
    assign ms_dest       = dest_q;
    assign ms_pc         = pc_q;
    assign ms_fwd_valid  = valid_state_s && gr_we_q;
    assign ms_fwd_dest   = ms_fwd_valid ? dest_q : {DEST_W{1'b0}};
    assign ms_fwd_result = ms_final_result;
    assign ms_fwd_busy   = (state_q == S_WAIT) && !data_sram_data_ok;

    // Next-state and response-buffer logic; an accept always wins because it
    // can only happen when the current entry leaves this cycle.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        case (state_q)
            S_EMPTY: begin
                if (accept_s) state_d = accept_state_s;
                else          state_d = S_EMPTY;
            end
            S_WAIT: begin
                if (data_sram_data_ok) begin
                    if (accept_s) begin
                        state_d = accept_state_s;
                    end else if (ms_flush || ws_allowin) begin
                        state_d = S_EMPTY;
                    end else begin
                        state_d = S_DONE;
                        buf_d   = live_word_s;
                    end
                end else if (ms_flush) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (accept_s)                     state_d = accept_state_s;
                else if (ms_flush || ws_allowin)  state_d = S_EMPTY;
                else                              state_d = S_DONE;
            end
            S_DRAIN: begin
                if (data_sram_data_ok) state_d = S_EMPTY;
                else                   state_d = S_DRAIN;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Payload capture on accept, hold otherwise
    always_comb begin
        if (accept_s) begin
            gr_we_d   = es_gr_we;
            dest_d    = es_dest;
            alu_d     = es_alu_result;
            op_d      = es_load_op;
            rt_d      = es_rt_value;
            pc_d      = es_pc;
            load_d    = es_res_from_mem && es_req_issued;
            res_mem_d = es_res_from_mem;
        end else begin
            gr_we_d   = gr_we_q;
            dest_d    = dest_q;
            alu_d     = alu_q;
            op_d      = op_q;
            rt_d      = rt_q;
            pc_d      = pc_q;
            load_d    = load_q;
            res_mem_d = res_mem_q;
        end
    end

    // State, payload and buffer registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_EMPTY;
            gr_we_q   <= 1'b0;
            dest_q    <= {DEST_W{1'b0}};
            alu_q     <= 32'd0;
            op_q      <= 3'd0;
            rt_q      <= 32'd0;
            pc_q      <= {PC_W{1'b0}};
            load_q    <= 1'b0;
            res_mem_q <= 1'b0;
            buf_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            gr_we_q   <= gr_we_d;
            dest_q    <= dest_d;
            alu_q     <= alu_d;
            op_q      <= op_d;
            rt_q      <= rt_d;
            pc_q      <= pc_d;
            load_q    <= load_d;
            res_mem_q <= res_mem_d;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Directed scenarios followed by a randomized phase. In the random phase the
// driver pushes the expected WB payload into a queue at each accept, a
// responder returns data a random number of cycles later, and an independent
// monitor compares the DUT outputs against the queue head every cycle.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic        es_res_from_mem;
    logic        es_req_issued;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic [31:0] es_alu_result;
    logic [2:0]  es_load_op;
    logic [31:0] es_rt_value;
    logic [31:0] es_pc;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_final_result;
    logic [31:0] ms_pc;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_result;
    logic        ms_fwd_busy;

    mem_stage_lsu dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_res_from_mem(es_res_from_mem), .es_req_issued(es_req_issued),
        .es_gr_we(es_gr_we), .es_dest(es_dest), .es_alu_result(es_alu_result),
        .es_load_op(es_load_op), .es_rt_value(es_rt_value), .es_pc(es_pc),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ms_flush(ms_flush), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
        .ms_final_result(ms_final_result), .ms_pc(ms_pc),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
        .ms_fwd_result(ms_fwd_result), .ms_fwd_busy(ms_fwd_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] pc;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_handoff = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    bit   resp_pending = 1'b0;
    int   resp_delay = 0;
    logic [31:0] resp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed from the load rules with plain arithmetic
    function automatic logic [31:0] ref_result(input bit load, input bit req,
                                               input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] word, input logic [31:0] rt);
        longint unsigned w, r, byte_v, half_v;
        int b, keep;
        w = word; r = rt; b = int'(addr[1:0]);
        if (!load) return addr;
        if (!req) return 32'd0;
        byte_v = (w >> (8 * b)) & 64'hFF;
        half_v = (w >> (16 * int'(addr[1]))) & 64'hFFFF;
        keep   = 8 * (3 - b);  // bits of rt preserved by LWL/LWR
        case (op)
            3'd1: return (byte_v >= 128) ? 32'(byte_v + 64'hFFFF_FF00) : 32'(byte_v);
            3'd2: return 32'(byte_v);
            3'd3: return (half_v >= 64'h8000) ? 32'(half_v + 64'hFFFF_0000) : 32'(half_v);
            3'd4: return 32'(half_v);
`ifdef MS_LWLR_EN
            3'd5: return 32'((w << keep) | (r & ((64'd1 << keep) - 64'd1)));
            3'd6: return 32'((w >> keep) | (r & ~(64'hFFFF_FFFF >> keep)));
`endif
            default: return word;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        es_to_ms_valid = 1'b0; es_res_from_mem = 1'b0; es_req_issued = 1'b0;
        es_gr_we = 1'b0; es_dest = 5'd0; es_alu_result = 32'd0; es_load_op = 3'd0;
        es_rt_value = 32'd0; es_pc = 32'd0; data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'd0; ms_flush = 1'b0;
    endtask

    task automatic issue(input bit load, input bit req, input bit we, input logic [4:0] dest,
                         input logic [31:0] addr, input logic [2:0] op, input logic [31:0] rt,
                         input logic [31:0] pc);
        es_to_ms_valid = 1'b1; es_res_from_mem = load; es_req_issued = req; es_gr_we = we;
        es_dest = dest; es_alu_result = addr; es_load_op = op; es_rt_value = rt; es_pc = pc;
    endtask

    // Monitor: compares DUT outputs with the scoreboard every cycle
    initial begin
        bit exp_valid, exp_busy, exp_allow;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_valid = (exp_q.size() != 0) && (!resp_pending || data_sram_data_ok) && !ms_flush;
                exp_busy  = (exp_q.size() != 0) && resp_pending && !data_sram_data_ok;
                exp_allow = ((exp_q.size() == 0) && !resp_pending) ||
                            ((exp_q.size() != 0) && (!resp_pending || data_sram_data_ok) && ws_allowin);
                chk("rnd_valid", {31'd0, ms_to_ws_valid}, {31'd0, exp_valid});
                chk("rnd_busy", {31'd0, ms_fwd_busy}, {31'd0, exp_busy});
                chk("rnd_allowin", {31'd0, ms_allowin}, {31'd0, exp_allow});
                if (exp_q.size() != 0) begin
                    chk("rnd_fwd_valid", {31'd0, ms_fwd_valid}, {31'd0, exp_q[0].gr_we});
                    chk("rnd_fwd_dest", {27'd0, ms_fwd_dest}, exp_q[0].gr_we ? {27'd0, exp_q[0].dest} : 32'd0);
                end else begin
                    chk("rnd_fwd_valid", {31'd0, ms_fwd_valid}, 32'd0);
                end
                if (exp_valid && ms_to_ws_valid) begin
                    chk("rnd_result", ms_final_result, exp_q[0].res);
                    chk("rnd_fwd_result", ms_fwd_result, exp_q[0].res);
                    chk("rnd_dest", {27'd0, ms_dest}, {27'd0, exp_q[0].dest});
                    chk("rnd_gr_we", {31'd0, ms_gr_we}, {31'd0, exp_q[0].gr_we});
                    chk("rnd_pc", ms_pc, exp_q[0].pc);
                    if (ws_allowin) begin
                        exp_q.delete(0);
                        n_handoff++;
                    end
                end
            end
        end
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    // Driver: directed scenarios then randomized traffic
    initial begin
        bit          t_valid, t_load, t_req, t_we, acc, stuck;
        logic [4:0]  t_dest;
        logic [2:0]  t_op;
        logic [31:0] t_addr, t_rt, t_pc, t_rdata;
        exp_t        t_exp;
        int          t_wait;

        resetn = 1'b0; ws_allowin = 1'b1; idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("rst_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("rst_fwd_valid", {31'd0, ms_fwd_valid}, 32'd0);
        chk("rst_fwd_dest", {27'd0, ms_fwd_dest}, 32'd0);
        chk("rst_fwd_busy", {31'd0, ms_fwd_busy}, 32'd0);
        chk("rst_fwd_result", ms_fwd_result, 32'd0);
        chk("rst_pc", ms_pc, 32'd0);
        step();
        resetn = 1'b1;

        // LB with a 2-cycle response latency
        issue(1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 3'd1, 32'd0, 32'h100);
        step(); es_to_ms_valid = 1'b0;
        @(negedge clk); chk("lb_busy1", {31'd0, ms_fwd_busy}, 32'd1);
        chk("lb_valid_wait", {31'd0, ms_to_ws_valid}, 32'd0);
        step();
        @(negedge clk); chk("lb_busy2", {31'd0, ms_fwd_busy}, 32'd1);
        step(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_1234;
        @(negedge clk); chk("lb_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        chk("lb_result", ms_final_result, 32'hFFFF_FF80);
        chk("lb_busy_done", {31'd0, ms_fwd_busy}, 32'd0);
        chk("lb_fwd_dest", {27'd0, ms_fwd_dest}, 32'd3);
        step(); data_sram_data_ok = 1'b0;
        @(negedge clk); chk("lb_empty_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("lb_empty_allowin", {31'd0, ms_allowin}, 32'd1);

        // LHU held in the buffer while WB stalls
        issue(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0002, 3'd4, 32'd0, 32'h104);
        step(); es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000;
        @(negedge clk); chk("lhu_result_ok", ms_final_result, 32'h0000_8001);
        chk("lhu_allowin_ok", {31'd0, ms_allowin}, 32'd0);
        step(); data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("lhu_hold_result", ms_final_result, 32'h0000_8001);
            chk("lhu_hold_valid", {31'd0, ms_to_ws_valid}, 32'd1);
            chk("lhu_hold_allowin", {31'd0, ms_allowin}, 32'd0);
            step();
        end
        ws_allowin = 1'b1;
        @(negedge clk); chk("lhu_release_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("lhu_release_result", ms_final_result, 32'h0000_8001);
        step();
        @(negedge clk); chk("lhu_gone", {31'd0, ms_to_ws_valid}, 32'd0);

        // Back-to-back ALU operations
        issue(1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0055, 3'd0, 32'd0, 32'h108);
        step(); issue(1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_00AA, 3'd0, 32'd0, 32'h10C);
        @(negedge clk); chk("alu1_result", ms_final_result, 32'h55);
        chk("alu1_fwd_dest", {27'd0, ms_fwd_dest}, 32'd7);
        chk("alu1_allowin", {31'd0, ms_allowin}, 32'd1);
        step(); es_to_ms_valid = 1'b0;
        @(negedge clk); chk("alu2_result", ms_final_result, 32'hAA);
        chk("alu2_fwd_dest", {27'd0, ms_fwd_dest}, 32'd9);
        chk("alu2_valid", {31'd0, ms_to_ws_valid}, 32'd1);
        step();
        @(negedge clk); chk("alu_empty_fwd", {31'd0, ms_fwd_valid}, 32'd0);

        // Flush while waiting, response arrives 3 cycles later
        issue(1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_0000, 3'd0, 32'd0, 32'h110);
        step(); es_to_ms_valid = 1'b0; ms_flush = 1'b1;
        @(negedge clk); chk("fl_valid0", {31'd0, ms_to_ws_valid}, 32'd0);
        step(); ms_flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); chk("fl_drain_allowin", {31'd0, ms_allowin}, 32'd0);
            chk("fl_drain_fwd", {31'd0, ms_fwd_valid}, 32'd0);
            step();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        @(negedge clk); chk("fl_dok_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("fl_dok_allowin", {31'd0, ms_allowin}, 32'd0);
        step(); data_sram_data_ok = 1'b0;
        @(negedge clk); chk("fl_after_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("fl_after_valid", {31'd0, ms_to_ws_valid}, 32'd0);

        // Asynchronous reset in the middle of a wait
        issue(1'b1, 1'b1, 1'b1, 5'd6, 32'h0000_0004, 3'd0, 32'd0, 32'h114);
        step(); es_to_ms_valid = 1'b0;
        @(negedge clk); chk("ar_busy", {31'd0, ms_fwd_busy}, 32'd1);
        resetn = 1'b0; #1;
        chk("ar_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        chk("ar_allowin", {31'd0, ms_allowin}, 32'd1);
        chk("ar_fwd_valid", {31'd0, ms_fwd_valid}, 32'd0);
        step(); resetn = 1'b1;

`ifdef MS_LWLR_EN
        issue(1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_0001, 3'd5, 32'h1122_3344, 32'h118);
        step(); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD;
        @(negedge clk); chk("lwl_result", ms_final_result, 32'hCCDD_3344);
        step(); data_sram_data_ok = 1'b0;
        issue(1'b1, 1'b1, 1'b1, 5'd8, 32'h0000_0002, 3'd6, 32'h1122_3344, 32'h11C);
        step(); es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD;
        @(negedge clk); chk("lwr_result", ms_final_result, 32'h11AA_BBCC);
        step(); data_sram_data_ok = 1'b0;
`endif

        // Randomized traffic against the scoreboard
        idle(); mon_en = 1'b1; t_valid = 1'b0; stuck = 1'b0; t_wait = 0;
        for (int cyc = 0; cyc < 3000 && !stuck; cyc++) begin
            if (!t_valid && ($urandom % 4 != 0)) begin
                int kind;
                kind    = int'($urandom % 10);
                t_load  = (kind >= 4);
                t_req   = (kind < 9);
                t_we    = ($urandom % 5 != 0);
                t_dest  = 5'($urandom);
                t_op    = 3'($urandom % 7);
                t_addr  = $urandom; t_rt = $urandom; t_pc = $urandom; t_rdata = $urandom;
                t_exp.res   = ref_result(t_load, t_req, t_op, t_addr, t_rdata, t_rt);
                t_exp.dest  = t_dest;
                t_exp.gr_we = t_we;
                t_exp.pc    = t_pc;
                t_valid = 1'b1; t_wait = 0;
            end
            if (t_valid) issue(t_load, t_req, t_we, t_dest, t_addr, t_op, t_rt, t_pc);
            else         es_to_ms_valid = 1'b0;
            ws_allowin = ($urandom % 4 != 0);
            ms_flush   = ($urandom % 20 == 0);
            if (resp_pending && resp_delay == 0) begin
                data_sram_data_ok = 1'b1; data_sram_rdata = resp_data;
            end else begin
                data_sram_data_ok = 1'b0; data_sram_rdata = $urandom;
            end
            @(negedge clk);
            acc = es_to_ms_valid && ms_allowin;
            @(posedge clk);
            if (ms_flush && exp_q.size() != 0) exp_q.delete(0);
            if (data_sram_data_ok)                     resp_pending = 1'b0;
            else if (resp_pending && resp_delay != 0)  resp_delay--;
            if (acc) begin
                exp_q.push_back(t_exp);
                if (t_load && t_req) begin
                    resp_pending = 1'b1;
                    resp_delay   = int'($urandom % 4);
                    resp_data    = t_rdata;
                end
                t_valid = 1'b0;
            end else if (t_valid) begin
                t_wait++;
                if (t_wait > 64) begin
                    n_checks++; n_errors++;
                    $display("FAIL stall: instruction not accepted after %0d cycles", t_wait);
                    stuck = 1'b1;
                end
            end
            #1;
        end
        mon_en = 1'b0;
        n_checks++;
        if (n_handoff < 200) begin
            n_errors++;
            $display("FAIL handoff_count: got %0d expected at least 200", n_handoff);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
